// File: rtl/mips_mdu.sv
// Multicycle MIPS multiply/divide unit with architectural HI/LO registers.
// Multiply completes after MULT_CYCLES; divide is 32-step restoring plus a sign-fix cycle.
module mips_mdu #(
   parameter int MULT_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic [63:0] prod;
   logic [31:0] quot, rem, dvs, dvd_raw;
   logic        neg_q, neg_r, div_zero;

   // Operand conditioning at issue: sign extension for MULT, magnitudes for DIV.
   logic        sgn_mul, sgn_div, neg_a, neg_b;
   logic [63:0] a_ext, b_ext;
   assign sgn_mul = (op == OP_MULT);
   assign sgn_div = (op == OP_DIV);
   assign a_ext   = {{32{sgn_mul & a[31]}}, a};
   assign b_ext   = {{32{sgn_mul & b[31]}}, b};
   assign neg_a   = sgn_div & a[31];
   assign neg_b   = sgn_div & b[31];

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   logic [32:0] shifted, diff;
   logic [31:0] rem_step;
   logic        fits;
   always_comb begin
      shifted  = {rem, quot[31]};
      diff     = shifted - {1'b0, dvs};
      fits     = ~diff[32];
      rem_step = fits ? diff[31:0] : shifted[31:0];
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) begin
            if (op == OP_MULT || op == OP_MULTU)    state_next = MUL;
            else if (op == OP_DIV || op == OP_DIVU) state_next = DIV;
         end
         MUL:     if (cnt == 5'd0) state_next = IDLE;
         DIV:     if (cnt == 5'd0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         prod     <= '0;
         quot     <= '0;
         rem      <= '0;
         dvs      <= '0;
         dvd_raw  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     prod <= a_ext * b_ext;
                     cnt  <= MUL_LOAD;
                  end
                  OP_DIV, OP_DIVU: begin
                     quot     <= neg_a ? -a : a;
                     dvs      <= neg_b ? -b : b;
                     rem      <= '0;
                     neg_q    <= neg_a ^ neg_b;
                     neg_r    <= neg_a;
                     div_zero <= (b == 32'd0);
                     dvd_raw  <= a;
                     cnt      <= 5'd31;
                  end
                  OP_MTHI: hi <= a;
                  OP_MTLO: lo <= a;
                  default: ;
               endcase
            end
            MUL: begin
               if (cnt == 5'd0) begin
                  {hi, lo} <= prod;
                  done     <= 1'b1;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            DIV: begin
               quot <= {quot[30:0], fits};
               rem  <= rem_step;
               if (cnt != 5'd0) cnt <= cnt - 5'd1;
            end
            FIX: begin
               done <= 1'b1;
               if (div_zero) begin
                  lo <= 32'hFFFF_FFFF;
                  hi <= dvd_raw;
               end else begin
                  lo <= neg_q ? -quot : quot;
                  hi <= neg_r ? -rem : rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
